// File: rtl/dump_pkg.sv
// Shared types and constants for the architectural-state dumper.
// The tag layout is {source, index}: source 0 = register file, 1 = data memory.
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RF,
        DM,
        DRAIN,
        DONE
    } state_t;

    localparam int TAG_W = 8;
    localparam int IDX_W = 7;

    localparam logic TAG_RF = 1'b0;
    localparam logic TAG_DM = 1'b1;

    function automatic logic [TAG_W-1:0] make_tag(input logic src, input logic [IDX_W-1:0] idx);
        return {src, idx};
    endfunction

endpackage

// File: rtl/state_dump_unit_if.sv
// Read ports into the CPU state plus the tagged output stream of the dumper.
// master = dumper side, slave = memories and stream sink.
interface state_dump_unit_if #(
    parameter int DATA_W = 32
) ();

    logic [4:0]                 rf_addr_o;
    logic [DATA_W-1:0]          rf_data_i;
    logic [31:0]                dm_addr_o;
    logic [DATA_W-1:0]          dm_data_i;
    logic                       dout_valid_o;
    logic                       dout_ready_i;
    logic [DATA_W-1:0]          dout_data_o;
    logic [dump_pkg::TAG_W-1:0] dout_tag_o;
    logic                       dout_last_o;

    modport master (
        output rf_addr_o,
        input  rf_data_i,
        output dm_addr_o,
        input  dm_data_i,
        output dout_valid_o,
        input  dout_ready_i,
        output dout_data_o,
        output dout_tag_o,
        output dout_last_o
    );

    modport slave (
        input  rf_addr_o,
        output rf_data_i,
        input  dm_addr_o,
        output dm_data_i,
        input  dout_valid_o,
        output dout_ready_i,
        input  dout_data_o,
        input  dout_tag_o,
        input  dout_last_o
    );

endinterface

// File: rtl/dump_out_reg.sv
// One-entry valid/ready holding register for the dump stream.
// A new word may be loaded whenever the slot is empty or is being accepted this cycle.
module dump_out_reg
    import dump_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              last,
    output logic              can_load
);

    assign can_load = !valid || ready;

    // Load wins over accept, so back-to-back words stream at one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/state_dump_unit.sv
// Streams the 32 register-file entries then NUM_MEM data-memory words as tagged words.
// Optional macro DUMP_CYCLE_TRIGGER_EN adds a one-shot auto-trigger TRIGGER_CYCLE cycles after reset.
module state_dump_unit
    import dump_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter int          NUM_MEM  = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] DM_BASE  = 32'h0
`ifdef DUMP_CYCLE_TRIGGER_EN
    ,
    parameter int          TRIGGER_CYCLE = 1200
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    state_dump_unit_if.master dump,
    output logic              busy_o,
    output logic              done_o
);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               trigger;
    logic               can_load;
    logic               load;
    logic               handshake;
    logic               at_end_rf;
    logic               at_end_dm;
    logic [DATA_W-1:0]  load_data;
    logic [TAG_W-1:0]   load_tag;
    logic               load_last;

`ifdef DUMP_CYCLE_TRIGGER_EN
    logic [31:0] cycle_count;

    // Parks one past the trigger value so the trigger is a single pulse per reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_count <= '0;
        end else if (cycle_count != 32'(TRIGGER_CYCLE)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign trigger = (cycle_count == 32'(TRIGGER_CYCLE - 1));
`else
    assign trigger = 1'b0;
`endif

    assign dump.rf_addr_o = idx[4:0];
    assign dump.dm_addr_o = DM_BASE + {23'd0, idx, 2'b00};

    assign at_end_rf = (idx == IDX_W'(NUM_REGS - 1));
    assign at_end_dm = (idx == IDX_W'(NUM_MEM - 1));
    assign load      = ((state == RF) || (state == DM)) && can_load;
    assign handshake = dump.dout_valid_o && dump.dout_ready_i;
    assign load_data = (state == DM) ? dump.dm_data_i : dump.rf_data_i;
    assign load_tag  = make_tag((state == DM) ? TAG_DM : TAG_RF, idx);
    assign load_last = (state == DM) && at_end_dm;

    dump_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (load),
        .load_data (load_data),
        .load_tag  (load_tag),
        .load_last (load_last),
        .ready     (dump.dout_ready_i),
        .valid     (dump.dout_valid_o),
        .data      (dump.dout_data_o),
        .tag       (dump.dout_tag_o),
        .last      (dump.dout_last_o),
        .can_load  (can_load)
    );

    // idx only moves on a capture, which keeps the read address pinned while the sink stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            idx    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i || trigger) begin
                        state  <= RF;
                        busy_o <= 1'b1;
                    end
                end
                RF: begin
                    if (load) begin
                        if (at_end_rf) begin
                            state <= DM;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DM: begin
                    if (load) begin
                        if (at_end_dm) begin
                            state <= DRAIN;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: cycle table, scoreboard-checked dumps, stall/reset/restart sequences.
// With DUMP_CYCLE_TRIGGER_EN defined it also checks the one-shot auto-trigger.
module tb_state_dump_unit;
    import dump_pkg::*;

    localparam int          NUM_REGS      = 32;
    localparam int          NUM_MEM       = 32;
    localparam int          DATA_W        = 32;
    localparam logic [31:0] DM_BASE       = 32'h0000_1000;
    localparam int          TRIGGER_CYCLE = 1200;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
        logic        last;
    } word_t;

    typedef struct {
        logic        rst;
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic        exp_busy;
        logic        exp_done;
        logic [31:0] exp_data;
        logic [7:0]  exp_tag;
        logic [4:0]  exp_rf_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    logic [31:0] rf_mem [NUM_REGS];
    logic [31:0] dm_mem [NUM_MEM];
    logic [31:0] dm_off;

    word_t exp_q [$];
    word_t cur_word;
    word_t prev_word;
    word_t exp_word;
    logic  mon_en = 1'b0;
    logic  prev_stall = 1'b0;
    logic  prev_hs_last = 1'b0;

    int checks = 0;
    int errors = 0;

    state_dump_unit_if #(.DATA_W(DATA_W)) bus ();

    state_dump_unit #(
        .NUM_REGS (NUM_REGS),
        .NUM_MEM  (NUM_MEM),
        .DATA_W   (DATA_W),
        .DM_BASE  (DM_BASE)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .dump    (bus.master),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    // Combinational memories: any address outside the DM window reads a poison value.
    assign dm_off = bus.dm_addr_o - DM_BASE;
    always_comb bus.rf_data_i = rf_mem[bus.rf_addr_o];
    always_comb begin
        bus.dm_data_i = 32'hDEAD_BEEF;
        if (dm_off[1:0] == 2'b00 && dm_off < 32'(4 * NUM_MEM)) begin
            bus.dm_data_i = dm_mem[dm_off[6:2]];
        end
    end

    assign cur_word = {bus.dout_data_o, bus.dout_tag_o, bus.dout_last_o};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the next expected word, stalls must hold, done follows last.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done_pulse", 64'(done), 64'(prev_hs_last));
            if (prev_stall) begin
                check("stall_hold", 64'({bus.dout_valid_o, cur_word}), 64'({1'b1, prev_word}));
            end
            if (bus.dout_valid_o && bus.dout_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stream_extra: actual=0x%0h required=none", cur_word);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("stream_word", 64'(cur_word), 64'(exp_word));
                end
            end
            prev_stall   <= bus.dout_valid_o && !bus.dout_ready_i;
            prev_word    <= cur_word;
            prev_hs_last <= bus.dout_valid_o && bus.dout_ready_i && bus.dout_last_o;
        end else begin
            prev_stall   <= 1'b0;
            prev_hs_last <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance past one rising edge; outputs then reflect that edge and new inputs apply to the next.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic rdy);
        rst              = r;
        start            = s;
        bus.dout_ready_i = rdy;
    endtask

    task automatic check_output(input vec_t v, input int row);
        string n;
        n = $sformatf("row%0d", row);
        check({n, "_valid"}, 64'(bus.dout_valid_o), 64'(v.exp_valid));
        check({n, "_busy"}, 64'(busy), 64'(v.exp_busy));
        check({n, "_done"}, 64'(done), 64'(v.exp_done));
        check({n, "_rf_addr"}, 64'(bus.rf_addr_o), 64'(v.exp_rf_addr));
        if (v.exp_valid) begin
            check({n, "_data"}, 64'(bus.dout_data_o), 64'(v.exp_data));
            check({n, "_tag"}, 64'(bus.dout_tag_o), 64'(v.exp_tag));
        end
    endtask

    function automatic void fill_linear();
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'(i * 3);
        for (int i = 0; i < NUM_MEM; i++) dm_mem[i] = 32'(100 + i);
    endfunction

    // Expected dump order: every RF entry, then every DM word, last flag on the final DM word.
    function automatic void push_dump();
        for (int i = 0; i < NUM_REGS; i++)
            exp_q.push_back('{data: rf_mem[i], tag: {TAG_RF, 7'(i)}, last: 1'b0});
        for (int i = 0; i < NUM_MEM; i++)
            exp_q.push_back('{data: dm_mem[i], tag: {TAG_DM, 7'(i)}, last: (i == NUM_MEM - 1)});
    endfunction

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            cycle();
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic wait_tag(input string name, input logic [7:0] t, input int bound);
        int n;
        n = 0;
        while (!(bus.dout_valid_o && bus.dout_tag_o == t) && n < bound) begin
            cycle();
            n++;
        end
        check({name, "_reach_tag"}, 64'(bus.dout_valid_o && bus.dout_tag_o == t), 64'(1));
    endtask

    vec_t vecs [10];

    initial begin
        int n;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00, 5'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 8'h00, 5'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 8'h00, 5'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 8'h00, 5'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 8'h01, 5'd2};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd6, 8'h02, 5'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6, 8'h02, 5'd3};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6, 8'h02, 5'd3};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00, 5'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00, 5'd0};

        fill_linear();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        cycle();
        cycle();

`ifdef DUMP_CYCLE_TRIGGER_EN
        $display("[TB] auto-trigger: busy must rise after edge %0d following reset release", TRIGGER_CYCLE);
        push_dump();
        mon_en = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!busy && n < TRIGGER_CYCLE + 100) begin
            cycle();
            n++;
        end
        check("trigger_edge", 64'(n), 64'(TRIGGER_CYCLE));
        wait_done("trigger", 200);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (busy) n++;
        end
        check("trigger_once", 64'(n), 64'(0));
        check("trigger_queue_empty", 64'(exp_q.size()), 64'(0));
        mon_en = 1'b0;
`else
        apply_stimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (busy) n++;
        end
        check("no_start_no_dump", 64'(n), 64'(0));
`endif

        $display("[TB] cycle table");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].start, vecs[i].ready);
            cycle();
            check_output(vecs[i], i);
            if (i == 0) check("reset_dm_addr", 64'(bus.dm_addr_o), 64'(DM_BASE));
        end

        $display("[TB] full dump with ready held high");
        fill_linear();
        push_dump();
        mon_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        cycle();
        check("lat_busy", 64'(busy), 64'(1));
        check("lat_no_valid_yet", 64'(bus.dout_valid_o), 64'(0));
        apply_stimulus(1'b0, 1'b0, 1'b1);
        cycle();
        check("lat_first_word", 64'(cur_word), 64'({32'd0, 8'h00, 1'b0}));
        n = 0;
        while (bus.dout_valid_o && n < 100) begin
            n++;
            cycle();
        end
        check("consecutive_valids", 64'(n), 64'(NUM_REGS + NUM_MEM));
        check("done_after_last", 64'(done), 64'(1));
        cycle();
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_not_busy", 64'(busy), 64'(0));
        check("dump1_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] random data with random ready");
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
        for (int i = 0; i < NUM_MEM; i++) dm_mem[i] = $urandom;
        push_dump();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        cycle();
        apply_stimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        n = 0;
        while (!done && n < 1000) begin
            cycle();
            bus.dout_ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        check("random_done_seen", 64'(done), 64'(1));
        bus.dout_ready_i = 1'b1;
        cycle();
        check("random_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] ten-cycle stall at r5");
        fill_linear();
        push_dump();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_tag("stall", 8'h05, 20);
        bus.dout_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stall_rf_addr", 64'(bus.rf_addr_o), 64'(6));
            check("stall_data", 64'(bus.dout_data_o), 64'(15));
            check("stall_tag", 64'(bus.dout_tag_o), 64'(8'h05));
        end
        bus.dout_ready_i = 1'b1;
        cycle();
        check("resume_data", 64'(bus.dout_data_o), 64'(18));
        check("resume_tag", 64'(bus.dout_tag_o), 64'(8'h06));
        wait_done("stall", 200);
        cycle();
        check("stall_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] start held high: back-to-back dumps");
        push_dump();
        push_dump();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        wait_done("b2b_first", 200);
        check("b2b_done_busy", 64'(busy), 64'(0));
        cycle();
        check("b2b_idle_busy", 64'(busy), 64'(0));
        check("b2b_idle_done", 64'(done), 64'(0));
        cycle();
        check("b2b_restart_busy", 64'(busy), 64'(1));
        wait_done("b2b_second", 200);
        start = 1'b0;
        cycle();
        cycle();
        check("b2b_stops", 64'(busy), 64'(0));
        check("b2b_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] reset in the middle of the DM phase");
        push_dump();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        cycle();
        start = 1'b0;
        wait_tag("midreset", 8'h8A, 100);
        mon_en = 1'b0;
        rst = 1'b1;
        cycle();
        check("midreset_valid", 64'(bus.dout_valid_o), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_rf_addr", 64'(bus.rf_addr_o), 64'(0));
        check("midreset_dm_addr", 64'(bus.dm_addr_o), 64'(DM_BASE));
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (done || busy) n++;
        end
        check("midreset_no_done", 64'(n), 64'(0));
        push_dump();
        mon_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        cycle();
        start = 1'b0;
        cycle();
        check("redump_first_word", 64'(cur_word), 64'({32'd0, 8'h00, 1'b0}));
        wait_done("redump", 200);
        cycle();
        check("redump_queue_empty", 64'(exp_q.size()), 64'(0));
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
